// File: rtl/ctrl_bus_pkg.sv
// Shared types and constants for the peripheral control-bus arbiter.
package ctrl_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StResp
  } state_e;

  // Cycles allowed for the peripheral to raise busy after a command strobe.
  localparam int unsigned BusyWaitCycles = 16;

  // Replicated across the data width when a transaction ends in error.
  localparam logic ErrReadBit = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches upward from the master after last_grant_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_grant_i,
  output logic [NumReq-1:0] grant_o
);

  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      idx = IdxW'((32'(last_grant_i) + i) % NumReq);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_bus_arbiter.sv
// Shares one peripheral control bus between several masters, one transaction at a time.
module ctrl_bus_arbiter
  import ctrl_bus_pkg::*;
#(
  parameter int unsigned g_NumMasters = 4,
  parameter int unsigned g_WidthADDR  = 8,
  parameter int unsigned g_WidthDATA  = 16,
  parameter int unsigned g_Timeout    = 255
) (
  input  logic                              Clock,
  input  logic                              Reset_N,
  input  logic [g_NumMasters-1:0]           M_req,
  input  logic [g_NumMasters-1:0]           M_write_read,
  input  logic [g_NumMasters*g_WidthADDR-1:0] M_addr_frame,
  input  logic [g_NumMasters*g_WidthDATA-1:0] M_write_data_frame,
  output logic [g_NumMasters-1:0]           M_done,
  output logic                              M_error,
  output logic [g_WidthDATA-1:0]            M_read_data_frame,
  output logic                              PRH_enable_cmd,
  output logic                              PRH_write_read,
  output logic [g_WidthADDR-1:0]            PRH_addr_frame,
  output logic [g_WidthDATA-1:0]            PRH_write_data_frame,
  input  logic                              PRH_busy,
  input  logic [g_WidthDATA-1:0]            PRH_read_data_frame
);

  localparam int unsigned IdxW    = (g_NumMasters > 1) ? $clog2(g_NumMasters) : 1;
  localparam int unsigned MaxWait = (g_Timeout > BusyWaitCycles) ? g_Timeout : BusyWaitCycles;
  localparam int unsigned CntW    = $clog2(MaxWait + 1);

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         last_grant_q, last_grant_d;
  logic [g_NumMasters-1:0] grant_q, grant_d;
  logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic                    en_q, en_d, wr_q, wr_d, err_q, err_d;
  logic [g_WidthADDR-1:0]  addr_q, addr_d;
  logic [g_WidthDATA-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic [g_NumMasters-1:0] done_q, done_d;

  logic [g_NumMasters-1:0] grant_oh;
  logic [IdxW-1:0]         grant_idx;

  rr_arbiter #(
    .NumReq (g_NumMasters),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req_i        (M_req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_oh)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < g_NumMasters; i++) begin
      if (grant_oh[i]) grant_idx = IdxW'(i);
    end
  end

  // Saturating so a stuck peripheral can never wrap the count back under the limit.
  assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    en_d         = 1'b0;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    done_d       = '0;
    err_d        = 1'b0;
    rdata_d      = '0;
    unique case (state_q)
      StIdle: begin
        if (|M_req) begin
          state_d      = StIssue;
          last_grant_d = grant_idx;
          grant_d      = grant_oh;
          en_d         = 1'b1;
          cnt_d        = '0;
          wr_d         = M_write_read[grant_idx];
          addr_d       = M_addr_frame[32'(grant_idx) * g_WidthADDR +: g_WidthADDR];
          wdata_d      = M_write_data_frame[32'(grant_idx) * g_WidthDATA +: g_WidthDATA];
        end
      end
      StIssue: begin
        state_d = StWaitBusy;
        cnt_d   = '0;
      end
      StWaitBusy: begin
        if (PRH_busy) begin
          state_d = StWaitDone;
          cnt_d   = '0;
        end else if (cnt_q >= CntW'(BusyWaitCycles - 1)) begin
          state_d = StResp;
          done_d  = grant_q;
          err_d   = 1'b1;
          rdata_d = {g_WidthDATA{ErrReadBit}};
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitDone: begin
        if (!PRH_busy) begin
          state_d = StResp;
          done_d  = grant_q;
          rdata_d = wr_q ? '0 : PRH_read_data_frame;
        end else if (cnt_q >= CntW'(g_Timeout - 1)) begin
          state_d = StResp;
          done_d  = grant_q;
          err_d   = 1'b1;
          rdata_d = {g_WidthDATA{ErrReadBit}};
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(g_NumMasters - 1);
      grant_q      <= '0;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign M_done               = done_q;
  assign M_error              = err_q;
  assign M_read_data_frame    = rdata_q;
  assign PRH_enable_cmd       = en_q;
  assign PRH_write_read       = wr_q;
  assign PRH_addr_frame       = addr_q;
  assign PRH_write_data_frame = wdata_q;

endmodule

// File: tb/tb_ctrl_bus_arbiter.sv
// Bench for ctrl_bus_arbiter: vector table plus hand sequences, scoreboard-checked.
module tb_ctrl_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic              Clock = 1'b0;
  logic              Reset_N;
  logic [N-1:0]      M_req;
  logic [N-1:0]      M_write_read;
  logic [N*AW-1:0]   M_addr_frame;
  logic [N*DW-1:0]   M_write_data_frame;
  logic [N-1:0]      M_done;
  logic              M_error;
  logic [DW-1:0]     M_read_data_frame;
  logic              PRH_enable_cmd;
  logic              PRH_write_read;
  logic [AW-1:0]     PRH_addr_frame;
  logic [DW-1:0]     PRH_write_data_frame;
  logic              PRH_busy = 1'b0;
  logic [DW-1:0]     PRH_read_data_frame;

  ctrl_bus_arbiter #(
    .g_NumMasters (N),
    .g_WidthADDR  (AW),
    .g_WidthDATA  (DW),
    .g_Timeout    (255)
  ) dut (
    .Clock                (Clock),
    .Reset_N              (Reset_N),
    .M_req                (M_req),
    .M_write_read         (M_write_read),
    .M_addr_frame         (M_addr_frame),
    .M_write_data_frame   (M_write_data_frame),
    .M_done               (M_done),
    .M_error              (M_error),
    .M_read_data_frame    (M_read_data_frame),
    .PRH_enable_cmd       (PRH_enable_cmd),
    .PRH_write_read       (PRH_write_read),
    .PRH_addr_frame       (PRH_addr_frame),
    .PRH_write_data_frame (PRH_write_data_frame),
    .PRH_busy             (PRH_busy),
    .PRH_read_data_frame  (PRH_read_data_frame)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int            master;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rd;
    int            lat;
  } exp_t;

  typedef struct {
    logic [N-1:0]  req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            mode;   // 0 busy for len cycles, 1 never busy, 2 stuck busy
    int            len;
    logic [DW-1:0] prd;
    int            grant;
    logic          err;
    logic [DW-1:0] rd;
    int            lat;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int            periph_mode = 0;
  int            periph_len  = 2;
  int            periph_rem  = 0;
  logic [DW-1:0] periph_rd   = '0;
  assign PRH_read_data_frame = periph_rd;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Peripheral model: busy rises on the strobe, held for periph_len cycles.
  always @(negedge Clock) begin
    if (!Reset_N || (|M_done)) begin
      PRH_busy = 1'b0;
    end else if (PRH_enable_cmd) begin
      if (periph_mode != 1) begin
        PRH_busy   = 1'b1;
        periph_rem = periph_len;
      end
    end else if (PRH_busy && periph_mode == 0) begin
      if (periph_rem <= 1) PRH_busy = 1'b0;
      else periph_rem--;
    end
  end

  // Scoreboard monitor.
  int cyc = 0;
  int strobe_cyc = 0;
  bit inflight = 1'b0;
  always @(negedge Clock) begin
    exp_t e;
    cyc++;
    if (!Reset_N) begin
      inflight = 1'b0;
    end else begin
      if (PRH_enable_cmd) begin
        check("strobe_overlap", 32'(inflight), 32'h0);
        check("strobe_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          check("strobe_addr", 32'(PRH_addr_frame), 32'(exp_q[0].addr));
          check("strobe_wr", 32'(PRH_write_read), 32'(exp_q[0].wr));
          check("strobe_wdata", 32'(PRH_write_data_frame), 32'(exp_q[0].wdata));
        end
        inflight   = 1'b1;
        strobe_cyc = cyc;
      end
      if (|M_done) begin
        check("done_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_onehot", 32'(M_done), 32'h1 << e.master);
          check("done_error", 32'(M_error), 32'(e.err));
          check("done_rdata", 32'(M_read_data_frame), 32'(e.rd));
          check("done_latency", 32'(cyc - strobe_cyc), 32'(e.lat));
          check("addr_stable", 32'(PRH_addr_frame), 32'(e.addr));
          check("wr_stable", 32'(PRH_write_read), 32'(e.wr));
        end
        inflight = 1'b0;
      end
    end
  end

  task automatic set_fields(input logic wr, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    for (int i = 0; i < N; i++) begin
      M_addr_frame[i*AW +: AW]       = ab + AW'(i);
      M_write_data_frame[i*DW +: DW] = db + DW'(i);
    end
    M_write_read = {N{wr}};
  endtask

  task automatic push_exp(input int m, input logic wr, input logic [AW-1:0] ab,
                          input logic [DW-1:0] db, input logic err, input logic [DW-1:0] rd,
                          input int lat);
    exp_t e;
    e.master = m;
    e.wr     = wr;
    e.addr   = ab + AW'(m);
    e.wdata  = db + DW'(m);
    e.err    = err;
    e.rd     = rd;
    e.lat    = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge Clock);
      seen = |M_done;
    end
    check("done_timeout", 32'(seen), 32'h1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_done"}, 32'(M_done), 32'h0);
    check({tag, "_m_error"}, 32'(M_error), 32'h0);
    check({tag, "_m_rdata"}, 32'(M_read_data_frame), 32'h0);
    check({tag, "_prh_en"}, 32'(PRH_enable_cmd), 32'h0);
    check({tag, "_prh_wr"}, 32'(PRH_write_read), 32'h0);
    check({tag, "_prh_addr"}, 32'(PRH_addr_frame), 32'h0);
    check({tag, "_prh_wdata"}, 32'(PRH_write_data_frame), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4'b0001, 1'b0, 8'h12, 16'h0000, 0, 3, 16'hBEEF, 0, 1'b0, 16'hBEEF, 4};
    vecs[1] = '{4'b0100, 1'b1, 8'h40, 16'h1234, 0, 2, 16'hDEAD, 2, 1'b0, 16'h0000, 3};
    vecs[2] = '{4'b0101, 1'b0, 8'h20, 16'h0000, 0, 4, 16'hA5A5, 0, 1'b0, 16'hA5A5, 5};
    vecs[3] = '{4'b1010, 1'b0, 8'h30, 16'h0000, 0, 3, 16'h5A5A, 1, 1'b0, 16'h5A5A, 4};
    vecs[4] = '{4'b1010, 1'b1, 8'h50, 16'hCAFE, 0, 2, 16'h7777, 3, 1'b0, 16'h0000, 3};
    vecs[5] = '{4'b0010, 1'b0, 8'h60, 16'h0000, 1, 0, 16'hFFFF, 1, 1'b1, 16'h0000, 17};
    vecs[6] = '{4'b1000, 1'b0, 8'h70, 16'h0000, 2, 0, 16'h1111, 3, 1'b1, 16'h0000, 257};

    Reset_N = 1'b0;
    M_req   = '0;
    set_fields(1'b0, 8'h00, 16'h0000);
    repeat (3) @(negedge Clock);
    check_outputs_zero("reset");
    Reset_N = 1'b1;
    @(negedge Clock);

    foreach (vecs[k]) begin
      set_fields(vecs[k].wr, vecs[k].addr, vecs[k].wdata);
      periph_mode = vecs[k].mode;
      periph_len  = vecs[k].len;
      periph_rd   = vecs[k].prd;
      push_exp(vecs[k].grant, vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].err,
               vecs[k].rd, vecs[k].lat);
      M_req = vecs[k].req;
      wait_done(400);
      M_req = '0;
      @(negedge Clock);
    end

    // Contention: all masters held, grants must rotate 0,1,2,3.
    set_fields(1'b1, 8'hC0, 16'h1000);
    periph_mode = 0;
    periph_len  = 2;
    for (int m = 0; m < N; m++) push_exp(m, 1'b1, 8'hC0, 16'h1000, 1'b0, 16'h0000, 3);
    M_req = 4'b1111;
    for (int t = 0; t < N; t++) wait_done(50);
    M_req = '0;
    @(negedge Clock);

    // Strobe one cycle after request; in-flight changes must not disturb the transaction.
    set_fields(1'b0, 8'h80, 16'h0000);
    periph_len = 3;
    periph_rd  = 16'h4242;
    push_exp(0, 1'b0, 8'h80, 16'h0000, 1'b0, 16'h4242, 4);
    M_req = 4'b0001;
    @(negedge Clock);
    check("grant_latency", 32'(PRH_enable_cmd), 32'h1);
    M_req             = 4'b1110;
    M_addr_frame[7:0] = 8'hFF;
    M_write_read      = 4'b1111;
    wait_done(50);
    M_req = '0;
    @(negedge Clock);

    // Reset while waiting on a stuck peripheral aborts silently and restores last_grant.
    set_fields(1'b0, 8'h90, 16'h0000);
    periph_mode = 2;
    push_exp(2, 1'b0, 8'h90, 16'h0000, 1'b0, 16'h0000, 0);
    M_req = 4'b0100;
    repeat (6) @(negedge Clock);
    Reset_N = 1'b0;
    M_req   = '0;
    exp_q.delete();
    @(negedge Clock);
    check_outputs_zero("midreset");
    @(negedge Clock);
    Reset_N     = 1'b1;
    periph_mode = 0;
    periph_len  = 2;
    periph_rd   = 16'h3C3C;
    set_fields(1'b0, 8'hA0, 16'h0000);
    push_exp(0, 1'b0, 8'hA0, 16'h0000, 1'b0, 16'h3C3C, 3);
    M_req = 4'b1111;
    wait_done(50);
    M_req = '0;
    repeat (3) @(negedge Clock);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_bus_arbiter.md
CTRL_BUS_ARBITER -- requirements
Module: ctrl_bus_arbiter

Interface
REQ-001 The block SHALL have parameter g_NumMasters, default 4, number of requesters sharing one peripheral control bus.
REQ-002 The block SHALL have parameter g_WidthADDR, default 8, address frame width.
REQ-003 The block SHALL have parameter g_WidthDATA, default 16, data frame width.
REQ-004 The block SHALL have parameter g_Timeout, default 255, max cycles waiting for busy to fall.
REQ-005 The block SHALL have port Clock, input, 1, single clock for all logic.
REQ-006 The block SHALL have port Reset_N, input, 1, reset that is synchronous and active-low.
REQ-007 The block SHALL have port M_req, input, g_NumMasters, per-master request level, held until M_done.
REQ-008 The block SHALL have port M_write_read, input, g_NumMasters, per-master direction, 1 = write.
REQ-009 The block SHALL have port M_addr_frame, input, g_NumMasters*g_WidthADDR, packed addresses, master i at slice i.
REQ-010 The block SHALL have port M_write_data_frame, input, g_NumMasters*g_WidthDATA, packed write data.
REQ-011 The block SHALL have port M_done, output, g_NumMasters, one-cycle completion pulse to the granted master.
REQ-012 The block SHALL have port M_error, output, 1, valid with M_done; 1 = timeout.
REQ-013 The block SHALL have port M_read_data_frame, output, g_WidthDATA, read data, valid with M_done.
REQ-014 The block SHALL have port PRH_enable_cmd, output, 1, one-cycle command strobe to peripheral.
REQ-015 The block SHALL have ports PRH_write_read (1), PRH_addr_frame (g_WidthADDR) and PRH_write_data_frame (g_WidthDATA), outputs, command fields.
REQ-016 The block SHALL have ports PRH_busy (1) and PRH_read_data_frame (g_WidthDATA), inputs, peripheral status and read data.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-018 In IDLE with any M_req set, the block SHALL grant round-robin starting at (last_grant+1) mod g_NumMasters, latch that master's fields, and go to ISSUE.
REQ-019 In ISSUE, the block SHALL drive PRH_enable_cmd=1 for exactly one cycle with latched fields, then go to WAIT_BUSY.
REQ-020 PRH_addr/data/write_read SHALL stay stable from ISSUE until return to IDLE.
REQ-021 In WAIT_BUSY, PRH_busy=1 SHALL move to WAIT_DONE; 16 cycles without busy SHALL set error and go to RESP.
REQ-022 In WAIT_DONE, PRH_busy=0 SHALL capture PRH_read_data_frame and go to RESP; g_Timeout cycles with busy high SHALL set error and go to RESP.
REQ-023 In RESP, the block SHALL pulse M_done[grant] for one cycle with M_error and M_read_data_frame, then return to IDLE.
REQ-024 On error, M_read_data_frame SHALL be 0.
REQ-025 For writes, M_read_data_frame SHALL be 0.
REQ-026 Grant-to-strobe latency SHALL be 1 cycle (request seen in IDLE -> PRH_enable_cmd on next cycle).
REQ-027 M_req changes of non-granted masters SHALL NOT affect the transaction in flight.
REQ-028 If the granted master drops M_req mid-transaction, the block SHALL still complete and pulse M_done.
REQ-029 The timeout counter SHALL saturate and SHALL NOT wrap.
REQ-030 Fields of a master SHALL be sampled only on the IDLE->ISSUE transition.

Reset
REQ-031 On Reset_N=0 at a rising Clock edge, the block SHALL enter IDLE and drive all outputs 0, set last_grant=g_NumMasters-1, and clear counters; reset mid-transaction SHALL abort without M_done.

Structure
REQ-032 FSM state type, busy-wait constant (16) and error read value SHALL reside in shared package ctrl_bus_pkg.
REQ-033 Round-robin grant logic SHALL be one sub-module rr_arbiter (inputs req vector and last_grant, output one-hot grant).

Verification
REQ-034 Single read: M_req=0001, addr 0x12, busy high 3 cycles, read data 0xBEEF -> one PRH_enable_cmd, M_done=0001, M_read_data_frame=0xBEEF, M_error=0.
REQ-035 Contention: M_req=1111 held for four transactions -> grants in order 0,1,2,3, no strobe overlap.
REQ-036 Fairness: after grant to master 2, M_req=0101 -> next grant is master 0.
REQ-037 No busy: peripheral never asserts busy -> M_done after 16 WAIT_BUSY cycles, M_error=1, data 0.
REQ-038 Stuck busy: busy held high -> M_done after 255 WAIT_DONE cycles, M_error=1.
REQ-039 Reset during WAIT_DONE -> next cycle all outputs 0, no M_done, fresh request from master 0 granted first.
